// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller.
//   state_e         : sweep FSM state encoding
//   DELTAS_ADDR_DEF : default bus address of the DDS phase-increment register
package dds_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DWELL = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [31:0] DELTAS_ADDR_DEF = 32'h0000_0008;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller. Steps the DDS phase increment from a start
// value by a signed step, holding each value for a number of sample strobes.
//
// Ports
//   clk, a_rst_n        : clock (rising edge), asynchronous active-low reset
//   i_start, i_stop     : single-cycle sweep start / abort requests
//   i_sample_en         : sample strobe, advances the dwell timer
//   i_delta_start/step  : first phase increment / signed per-step increment
//   i_step_count        : steps per sweep (0 behaves as 1)
//   i_dwell             : samples per step (0 behaves as 1)
//   i_continuous        : 1 = repeat sweep until stopped
//   o_write, o_addrs    : DDS bus write strobe and address
//   o_deltas_reg        : current phase increment
//   o_busy, o_done      : not-idle flag, one-cycle sweep-complete pulse
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; o_deltas_reg holds its last value
// ST_LOAD  | one-cycle bus write of the current delta; arms the dwell timer
// ST_DWELL | counting sample strobes until the dwell timer reaches zero
// ST_DONE  | one-cycle o_done pulse after a single sweep
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter logic [31:0] DELTAS_ADDR = DELTAS_ADDR_DEF,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             a_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_sample_en,
   input  logic [31:0]      i_delta_start,
   input  logic [31:0]      i_delta_step,
   input  logic [CNT_W-1:0] i_step_count,
   input  logic [CNT_W-1:0] i_dwell,
   input  logic             i_continuous,
   output logic             o_write,
   output logic [31:0]      o_addrs,
   output logic [31:0]      o_deltas_reg,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [31:0]      delta_q, delta_d;
   logic [31:0]      start_q, start_d;
   logic [31:0]      step_q, step_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             cont_q, cont_d;
   logic [CNT_W-1:0] step_idx_q, step_idx_d;
   logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_q     <= ST_IDLE;
         delta_q     <= '0;
         start_q     <= '0;
         step_q      <= '0;
         count_q     <= '0;
         dwell_q     <= '0;
         cont_q      <= 1'b0;
         step_idx_q  <= '0;
         dwell_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         delta_q     <= delta_d;
         start_q     <= start_d;
         step_q      <= step_d;
         count_q     <= count_d;
         dwell_q     <= dwell_d;
         cont_q      <= cont_d;
         step_idx_q  <= step_idx_d;
         dwell_cnt_q <= dwell_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      delta_d     = delta_q;
      start_d     = start_q;
      step_d      = step_q;
      count_d     = count_q;
      dwell_d     = dwell_q;
      cont_d      = cont_q;
      step_idx_d  = step_idx_q;
      dwell_cnt_d = dwell_cnt_q;

      // Abort wins over everything, including a step end in the same cycle.
      if (state_q != ST_IDLE && i_stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start && !i_stop) begin
                  start_d    = i_delta_start;
                  step_d     = i_delta_step;
                  count_d    = (i_step_count == '0) ? ONE : i_step_count;
                  dwell_d    = (i_dwell == '0) ? ONE : i_dwell;
                  cont_d     = i_continuous;
                  delta_d    = i_delta_start;
                  step_idx_d = '0;
                  state_d    = ST_LOAD;
               end
            end
            ST_LOAD: begin
               // Dwell timer counts down; it holds the number of strobes
               // still to come before the step-ending one.
               dwell_cnt_d = dwell_q - ONE;
               state_d     = ST_DWELL;
            end
            ST_DWELL: begin
               if (i_sample_en) begin
                  if (dwell_cnt_q != '0) begin
                     dwell_cnt_d = dwell_cnt_q - ONE;
                  end else if (step_idx_q != count_q - ONE) begin
                     delta_d    = delta_q + step_q;
                     step_idx_d = step_idx_q + ONE;
                     state_d    = ST_LOAD;
                  end else if (cont_q) begin
                     delta_d    = start_q;
                     step_idx_d = '0;
                     state_d    = ST_LOAD;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign o_write      = (state_q == ST_LOAD);
   assign o_addrs      = o_write ? DELTAS_ADDR : 32'h0;
   assign o_deltas_reg = delta_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

   localparam logic [31:0] ADDR = 32'h0000_0008;

   logic        clk = 1'b0;
   logic        a_rst_n;
   logic        i_start, i_stop, i_sample_en, i_continuous;
   logic [31:0] i_delta_start, i_delta_step;
   logic [15:0] i_step_count, i_dwell;
   logic        o_write, o_busy, o_done;
   logic [31:0] o_addrs, o_deltas_reg;

   int n_checks = 0;
   int n_fail   = 0;

   dds_sweep_ctrl #(.DELTAS_ADDR(ADDR), .CNT_W(16)) dut (
      .clk           (clk),
      .a_rst_n       (a_rst_n),
      .i_start       (i_start),
      .i_stop        (i_stop),
      .i_sample_en   (i_sample_en),
      .i_delta_start (i_delta_start),
      .i_delta_step  (i_delta_step),
      .i_step_count  (i_step_count),
      .i_dwell       (i_dwell),
      .i_continuous  (i_continuous),
      .o_write       (o_write),
      .o_addrs       (o_addrs),
      .o_deltas_reg  (o_deltas_reg),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      start;
      logic [31:0]      step;
      logic [15:0]      cnt;
      logic [15:0]      dwell;
      logic             cont;
      int               per;
      int               n_wr;
      logic [3:0][31:0] wr;
      int               n_done;
      int               gap;
      logic [31:0]      last;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [31:0] start, input logic [31:0] step,
                                input logic [15:0] cnt, input logic [15:0] dwell,
                                input logic cont, input int per, input int n_wr,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input int n_done, input int gap, input logic [31:0] last);
      vec_t v;
      v.start = start; v.step = step; v.cnt = cnt; v.dwell = dwell;
      v.cont = cont; v.per = per; v.n_wr = n_wr;
      v.wr[0] = w0; v.wr[1] = w1; v.wr[2] = w2; v.wr[3] = w3;
      v.n_done = n_done; v.gap = gap; v.last = last;
      return v;
   endfunction

   task automatic drive_cfg(input logic [31:0] start, input logic [31:0] step,
                            input logic [15:0] cnt, input logic [15:0] dwell, input logic cont);
      i_delta_start = start;
      i_delta_step  = step;
      i_step_count  = cnt;
      i_dwell       = dwell;
      i_continuous  = cont;
   endtask

   // Runs one table vector: start, watch writes until idle, stop continuous
   // sweeps after the expected number of writes.
   task automatic run_vec(input vec_t v, input int idx);
      int nwr = 0, ndone = 0, cyc = 0, last_w = 0;
      bit finished = 0;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      drive_cfg(v.start, v.step, v.cnt, v.dwell, v.cont);
      i_start     = 1'b1;
      i_sample_en = (v.per == 1);
      while (!finished && cyc < 400) begin
         @(negedge clk);
         cyc++;
         i_start = 1'b0;
         i_stop  = 1'b0;
         if (!o_busy) finished = 1;
         if (o_write) begin
            if (nwr < 4) chk({tag, "_wr_val"}, o_deltas_reg, v.wr[nwr]);
            chk({tag, "_wr_addr"}, o_addrs, ADDR);
            if (v.gap != 0 && nwr > 0) chk({tag, "_wr_gap"}, cyc - last_w, v.gap);
            last_w = cyc;
            nwr++;
            if (v.cont && nwr == v.n_wr) i_stop = 1'b1;
         end else begin
            chk({tag, "_addr_idle"}, o_addrs, 32'h0);
         end
         if (o_done) ndone++;
         i_sample_en = ((cyc % v.per) == (v.per - 1));
      end
      i_sample_en = 1'b0;
      chk({tag, "_finished"}, finished, 1'b1);
      chk({tag, "_n_writes"}, nwr, v.n_wr);
      chk({tag, "_n_done"}, ndone, v.n_done);
      chk({tag, "_hold_delta"}, o_deltas_reg, v.last);
   endtask

   initial begin
      int cyc;
      int nwr;
      int nbusy;
      int ndone;
      logic [31:0] held;

      a_rst_n = 1'b0;
      i_start = 1'b0; i_stop = 1'b0; i_sample_en = 1'b0;
      drive_cfg(32'h0, 32'h0, 16'h0, 16'h0, 1'b0);

      vecs[0] = mkv(32'h100, 32'h10, 16'd3, 16'd2, 1'b0, 1, 3,
                    32'h100, 32'h110, 32'h120, 32'h0, 1, 3, 32'h120);
      vecs[1] = mkv(32'h40, 32'h40, 16'd2, 16'd1, 1'b1, 1, 4,
                    32'h40, 32'h80, 32'h40, 32'h80, 0, 2, 32'h80);
      vecs[2] = mkv(32'h8, 32'hFFFF_FFF8, 16'd3, 16'd1, 1'b0, 2, 3,
                    32'h8, 32'h0, 32'hFFFF_FFF8, 32'h0, 1, 0, 32'hFFFF_FFF8);
      vecs[3] = mkv(32'h1234, 32'h5, 16'd0, 16'd0, 1'b0, 3, 1,
                    32'h1234, 32'h0, 32'h0, 32'h0, 1, 0, 32'h1234);
      vecs[4] = mkv(32'h77, 32'h3, 16'd1, 16'd3, 1'b0, 1, 1,
                    32'h77, 32'h0, 32'h0, 32'h0, 1, 0, 32'h77);
      vecs[5] = mkv(32'h10, 32'h20, 16'd2, 16'd0, 1'b0, 1, 2,
                    32'h10, 32'h30, 32'h0, 32'h0, 1, 2, 32'h30);

      // Reset state
      #12;
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_write", o_write, 1'b0);
      chk("rst_addrs", o_addrs, 32'h0);
      chk("rst_deltas", o_deltas_reg, 32'h0);
      chk("rst_done", o_done, 1'b0);
      @(negedge clk);
      a_rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", o_busy, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], i);
         repeat (2) @(negedge clk);
      end

      // Start together with stop is ignored
      drive_cfg(32'h55, 32'h1, 16'd1, 16'd1, 1'b0);
      i_start = 1'b1; i_stop = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_stop = 1'b0;
      chk("startstop_busy", o_busy, 1'b0);
      chk("startstop_write", o_write, 1'b0);

      // Start while busy is ignored and config stays latched mid-sweep
      drive_cfg(32'hA, 32'h0, 16'd2, 16'd4, 1'b0);
      i_start = 1'b1; i_sample_en = 1'b1;
      @(negedge clk);
      drive_cfg(32'hB, 32'h100, 16'd5, 16'd1, 1'b1);
      nwr = 0; ndone = 0; cyc = 0;
      if (o_write) begin
         chk("busy_start_wr", o_deltas_reg, 32'hA);
         nwr++;
      end
      while (o_busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
         i_start = (cyc < 3);
         if (o_write) begin
            chk("busy_start_wr", o_deltas_reg, 32'hA);
            nwr++;
         end
         if (o_done) ndone++;
      end
      i_start = 1'b0; i_sample_en = 1'b0;
      chk("busy_start_nwr", nwr, 2);
      chk("busy_start_done", ndone, 1);
      chk("busy_start_idle", o_busy, 1'b0);

      // Stop colliding with the end of the first step
      repeat (2) @(negedge clk);
      drive_cfg(32'h500, 32'h100, 16'd4, 16'd2, 1'b0);
      i_start = 1'b1; i_sample_en = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("stopcol_wr", o_write, 1'b1);
      chk("stopcol_wr_val", o_deltas_reg, 32'h500);
      repeat (2) @(negedge clk);
      chk("stopcol_in_dwell", o_busy, 1'b1);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
      chk("stopcol_busy", o_busy, 1'b0);
      chk("stopcol_write", o_write, 1'b0);
      chk("stopcol_done", o_done, 1'b0);
      chk("stopcol_hold", o_deltas_reg, 32'h500);
      nwr = 0; ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (o_write) nwr++;
         if (o_done) ndone++;
      end
      i_sample_en = 1'b0;
      chk("stopcol_no_wr", nwr, 0);
      chk("stopcol_no_done", ndone, 0);
      chk("stopcol_hold2", o_deltas_reg, 32'h500);

      // Reset in the middle of DWELL, strobe every 4th cycle
      drive_cfg(32'h900, 32'h1, 16'd3, 16'd3, 1'b0);
      i_start = 1'b1;
      cyc = 0;
      @(negedge clk);
      i_start = 1'b0;
      chk("rstmid_wr", o_deltas_reg, 32'h900);
      repeat (4) begin
         @(negedge clk);
         cyc++;
         i_sample_en = ((cyc % 4) == 3);
      end
      chk("rstmid_in_dwell", o_busy, 1'b1);
      #2 a_rst_n = 1'b0;
      #1;
      chk("rstmid_busy", o_busy, 1'b0);
      chk("rstmid_write", o_write, 1'b0);
      chk("rstmid_addrs", o_addrs, 32'h0);
      chk("rstmid_deltas", o_deltas_reg, 32'h0);
      chk("rstmid_done", o_done, 1'b0);
      @(negedge clk);
      a_rst_n = 1'b1;
      nwr = 0; nbusy = 0;
      repeat (30) begin
         @(negedge clk);
         cyc++;
         i_sample_en = ((cyc % 4) == 3);
         if (o_write) nwr++;
         if (o_busy) nbusy++;
      end
      chk("rstmid_no_wr", nwr, 0);
      chk("rstmid_no_busy", nbusy, 0);

      // A fresh start after reset works normally
      drive_cfg(32'hABC, 32'h1, 16'd1, 16'd1, 1'b0);
      i_start = 1'b1;
      nwr = 0; ndone = 0; held = 32'h0;
      @(negedge clk);
      i_start = 1'b0;
      cyc = 0;
      while (o_busy && cyc < 100) begin
         if (o_write) begin
            nwr++;
            held = o_deltas_reg;
         end
         if (o_done) ndone++;
         @(negedge clk);
         cyc++;
         i_sample_en = ((cyc % 4) == 3);
      end
      i_sample_en = 1'b0;
      chk("restart_nwr", nwr, 1);
      chk("restart_val", held, 32'hABC);
      chk("restart_done", ndone, 1);
      chk("restart_idle", o_busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
